// File: rtl/umips_mmio_ctrl.sv
// MMIO block: LED word, LCD command/status words and scratch words; rd is combinational.
// LCD transfers take T_SETUP+T_PULSE+T_HOLD cycles; command writes while busy are dropped and flagged in OVF.
module umips_mmio_ctrl #(
    parameter int NREGS   = 32,
    parameter int LED_W   = 10,
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 12,
    parameter int T_HOLD  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [31:0]      a0,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    output logic [LED_W-1:0] LEDG,
    output logic             LCD_EN,
    output logic             LCD_RS,
    output logic             LCD_RW,
    output logic [7:0]       LCD_DATA,
    output logic             lcd_busy
);

    localparam int AW    = $clog2(NREGS);
    localparam int TMAX1 = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int TMAX  = (TMAX1 > T_HOLD) ? TMAX1 : T_HOLD;
    localparam int CW    = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} lcd_state_t;

    lcd_state_t       state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [31:0]      mem [NREGS];
    logic [AW-1:0]    idx;
    logic             ovf;
    logic             lcd_rs_q;
    logic [7:0]       lcd_data_q;
    logic             en_q;
    logic             busy;
    logic             cmd_wr;
    logic             cmd_acc;
    logic             ovf_set;
    logic             ovf_clr;
    logic             mem_wr;
    logic             unused_addr;

    assign idx         = a0[AW+1:2];
    assign unused_addr = ^{a0[31:AW+2], a0[1:0]};

    assign busy    = (state != IDLE);
    assign cmd_wr  = we && (idx == AW'(1));
    assign cmd_acc = cmd_wr && !busy;
    assign ovf_set = cmd_wr && busy;
    assign ovf_clr = we && (idx == AW'(2)) && be[0] && wd[1];
    assign mem_wr  = we && (idx != AW'(1)) && (idx != AW'(2));

    // Words 1 and 2 live outside the array; their array slots stay at reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf        <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= '0;
        end else begin
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (cmd_acc) begin
                lcd_rs_q   <= wd[8];
                lcd_data_q <= wd[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            en_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            en_q  <= (state_nxt == PULSE);
        end
    end

    // Each phase loads its length minus one on entry and leaves when the count hits zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (cmd_acc) begin
                    state_nxt = SETUP;
                    cnt_nxt   = CW'(T_SETUP - 1);
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = PULSE;
                    cnt_nxt   = CW'(T_PULSE - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CW'(T_HOLD - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        rd = mem[idx];
        if (idx == AW'(1)) begin
            rd = {23'b0, lcd_rs_q, lcd_data_q};
        end else if (idx == AW'(2)) begin
            rd = {30'b0, ovf, busy};
        end
    end

    assign LEDG     = mem[0][LED_W-1:0];
    assign LCD_EN   = en_q;
    assign LCD_RS   = lcd_rs_q;
    assign LCD_RW   = 1'b0;
    assign LCD_DATA = lcd_data_q;
    assign lcd_busy = busy;

endmodule

// File: tb/tb_umips_mmio_ctrl.sv
// Directed bench for umips_mmio_ctrl: default instance plus an NREGS=8 instance on the same bus.
module tb_umips_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] a0 = 32'h0;
    logic [31:0] wd = 32'h0;
    logic [31:0] rd;
    logic [9:0]  ledg;
    logic        lcd_en, lcd_rs, lcd_rw, lcd_busy;
    logic [7:0]  lcd_data;

    logic [31:0] rd8;
    logic [9:0]  ledg8_unused;
    logic        en8_unused, rs8_unused, rw8_unused, busy8_unused;
    logic [7:0]  data8_unused;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    umips_mmio_ctrl dut (
        .clk(clk), .rst_n(rst_n), .we(we), .be(be), .a0(a0), .wd(wd), .rd(rd),
        .LEDG(ledg), .LCD_EN(lcd_en), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw),
        .LCD_DATA(lcd_data), .lcd_busy(lcd_busy)
    );

    umips_mmio_ctrl #(.NREGS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .we(we), .be(be), .a0(a0), .wd(wd), .rd(rd8),
        .LEDG(ledg8_unused), .LCD_EN(en8_unused), .LCD_RS(rs8_unused), .LCD_RW(rw8_unused),
        .LCD_DATA(data8_unused), .lcd_busy(busy8_unused)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] b);
        @(negedge clk);
        we = 1'b1; a0 = addr; wd = data; be = b;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        a0 = addr;
        #1 check(tag, rd, exp);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        @(negedge clk);
        while (lcd_busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (lcd_busy) check("idle_timeout", 32'(lcd_busy), 32'h0);
    endtask

    initial begin
        int en_first, en_last, en_cnt, busy_last;
        int k;

        repeat (2) @(negedge clk);
        check("rst_ledg", 32'(ledg), 32'h0);
        check("rst_en", 32'(lcd_en), 32'h0);
        check("rst_busy", 32'(lcd_busy), 32'h0);
        rst_n = 1'b1;
        check("rw_zero", 32'(lcd_rw), 32'h0);
        rd_chk("rst_rd0", 32'h0, 32'h0);

        // Byte-enable writes on the LED word and a scratch word
        wr(32'h0, 32'h0000_03FF, 4'b1111);
        wr(32'h0, 32'h0000_0000, 4'b0010);
        #1 check("ledg_be", 32'(ledg), 32'h0FF);
        rd_chk("rd0_be", 32'h0, 32'h0000_00FF);
        wr(32'hC, 32'hA5A5_A5A5, 4'b1111);
        wr(32'hC, 32'h1122_3344, 4'b0101);
        rd_chk("scratch_be", 32'hC, 32'hA522_A544);
        wr(32'h8, 32'hFFFF_FFFC, 4'b1111);
        rd_chk("status_ro", 32'h8, 32'h0);

        // Transfer timing relative to the accepting edge N
        wr(32'h4, 32'h0000_0141, 4'b0000);
        en_first = 0; en_last = 0; en_cnt = 0; busy_last = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (lcd_en) begin
                if (en_first == 0) en_first = c;
                en_last = c;
                en_cnt++;
            end
            if (lcd_busy) busy_last = c;
            if (c == 1) check("busy_first", 32'(lcd_busy), 32'h1);
        end
        check("lcd_rs", 32'(lcd_rs), 32'h1);
        check("lcd_data", 32'(lcd_data), 32'h41);
        check("en_first", 32'(en_first), 32'd3);
        check("en_last", 32'(en_last), 32'd14);
        check("en_cnt", 32'(en_cnt), 32'd12);
        check("busy_last", 32'(busy_last), 32'd16);
        rd_chk("rd_cmd", 32'h4, 32'h0000_0141);

        // Overrun: second command dropped, OVF set then cleared
        wr(32'h4, 32'h0000_0038, 4'b1111);
        repeat (2) @(posedge clk);
        wr(32'h4, 32'h0000_000C, 4'b1111);
        #1 check("ovf_data", 32'(lcd_data), 32'h38);
        rd_chk("ovf_cmd", 32'h4, 32'h0000_0038);
        rd_chk("ovf_stat", 32'h8, 32'h3);
        wr(32'h8, 32'h0000_0002, 4'b0001);
        rd_chk("ovf_clr", 32'h8, 32'h1);
        wait_idle(40);
        rd_chk("stat_done", 32'h8, 32'h0);

        // Back-to-back: write in the very first idle cycle
        wr(32'h4, 32'h0000_0155, 4'b1111);
        wait_idle(40);
        we = 1'b1; a0 = 32'h4; wd = 32'h0000_00AA; be = 4'b1111;
        @(posedge clk);
        #1 we = 1'b0;
        @(negedge clk);
        check("b2b_busy", 32'(lcd_busy), 32'h1);
        check("b2b_data", 32'(lcd_data), 32'hAA);
        rd_chk("b2b_stat", 32'h8, 32'h1);

        // Async reset during PULSE
        k = 0;
        while (!lcd_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("pulse_seen", 32'(lcd_en), 32'h1);
        #2 rst_n = 1'b0;
        #1 check("arst_en", 32'(lcd_en), 32'h0);
        check("arst_busy", 32'(lcd_busy), 32'h0);
        @(negedge clk);
        we = 1'b1; a0 = 32'h0; wd = 32'hFFFF_FFFF; be = 4'b1111;
        @(posedge clk);
        #1 we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("post_rd0", 32'h0, 32'h0);
        rd_chk("post_rd1", 32'h4, 32'h0);
        rd_chk("post_rd2", 32'h8, 32'h0);
        rd_chk("post_rd3", 32'hC, 32'h0);
        check("post_ledg", 32'(ledg), 32'h0);

        // Upper address bits ignored with NREGS=8
        wr(32'h1C, 32'hDEAD_BEEF, 4'b1111);
        a0 = 32'h3C;
        #1 check("alias8", rd8, 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/umips_mmio_ctrl.md
UMIPS_MMIO_CTRL -- requirements
Module: umips_mmio_ctrl

Interface
REQ-001 Parameter NREGS, default 32, is the number of 32-bit MMIO words; it SHALL be a power of two and at least 4.
REQ-002 Parameter LED_W, default 10, is the LED output width; it SHALL be between 1 and 32.
REQ-003 Parameter T_SETUP, default 2, is the cycles RS/DATA are stable before EN rises; it SHALL be at least 1.
REQ-004 Parameter T_PULSE, default 12, is the cycles EN is held high; it SHALL be at least 1.
REQ-005 Parameter T_HOLD, default 2, is the cycles RS/DATA are held after EN falls; it SHALL be at least 1.
REQ-006 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-008 we  input  1  write strobe.
REQ-009 be  input  4  byte enables; be[i] gates wd[8i+7:8i].
REQ-010 a0  input  32  byte address; word index = a0[log2(NREGS)+1:2]; other bits ignored.
REQ-011 wd  input  32  write data.
REQ-012 rd  output  32  combinational read data for the word at a0.
REQ-013 LEDG  output  LED_W  equals reg0[LED_W-1:0].
REQ-014 LCD_EN, LCD_RS, LCD_RW  output  1 each  LCD strobe, register select, read/write.
REQ-015 LCD_DATA  output  8  LCD data bus.
REQ-016 lcd_busy  output  1  high while a transfer is in progress.

Function
REQ-017 Word 0 (LED) and words 3..NREGS-1 (scratch) SHALL be read/write, with per-byte writes honoring be.
REQ-018 Word 1 (LCD_CMD) SHALL ignore be; a write while idle SHALL latch RS=wd[8], DATA=wd[7:0] and start a transfer.
REQ-019 A word-1 write while busy SHALL be dropped, leave the latched command unchanged, and set sticky OVF.
REQ-020 Word 2 (STATUS) SHALL read {30'b0, OVF, busy}; writing 1 to bit 1 with be[0]=1 SHALL clear OVF, and all other bits SHALL be read-only.
REQ-021 If an OVF-setting write and an OVF-clear write coincide, set SHALL win; they cannot coincide on a single port, so this holds by construction.
REQ-022 Reading word 1 SHALL return {23'b0, RS, DATA} from the last accepted command.
REQ-023 The transfer FSM SHALL use states IDLE, SETUP, PULSE, HOLD.
REQ-024 FSM transitions: IDLE->SETUP on an accepted write; SETUP->PULSE after T_SETUP cycles; PULSE->HOLD after T_PULSE cycles; HOLD->IDLE after T_HOLD cycles.
REQ-025 For a write accepted at edge N: SETUP SHALL run N+1..N+T_SETUP, EN high exactly T_PULSE cycles, then HOLD T_HOLD cycles, and busy low from edge N+T_SETUP+T_PULSE+T_HOLD.
REQ-026 lcd_busy SHALL be high in SETUP, PULSE and HOLD, and first high in the cycle after the accepting edge.
REQ-027 LCD_EN SHALL be high only in PULSE and SHALL be glitch-free (driven from a register).
REQ-028 LCD_RS and LCD_DATA SHALL present the latched command at all times, stable from SETUP through HOLD.
REQ-029 LCD_RW SHALL be constant 0 (write-only).
REQ-030 A new write arriving in the same cycle busy falls (the first IDLE cycle) SHALL be accepted.
REQ-031 The phase counter SHALL be wide enough for max(T_SETUP, T_PULSE, T_HOLD) and SHALL reload on each state entry.

Reset
REQ-032 While rst_n is low, all words, OVF, RS and DATA SHALL be 0, the FSM SHALL be IDLE, and LCD_EN, lcd_busy and LEDG SHALL be 0.
REQ-033 Reset asserted mid-transfer SHALL drop LCD_EN immediately (asynchronously) and abort the transfer.
REQ-034 Writes SHALL be ignored while rst_n is low; the block SHALL be operable on the first rising edge after rst_n deasserts.

Verification
REQ-035 Write word0=0x0000_03FF with be=4'b1111, then 0x0 with be=4'b0010 -> LEDG=0x0FF; rd@0=0x0000_00FF.
REQ-036 Defaults; write word1=0x0000_0141 at edge N -> RS=1, DATA=0x41, EN high N+3..N+14 (12 cycles), busy low from N+16.
REQ-037 Write word1=0x38, then word1=0x0C three cycles later -> second write dropped, DATA stays 0x38, rd@2=0x3; write word2=0x2 -> rd@2=0x1 (until done), then 0x0.
REQ-038 Write word1 in the first cycle busy is low after a prior transfer -> accepted; busy high the next cycle; no OVF.
REQ-039 Assert rst_n=0 during PULSE -> LCD_EN=0 and busy=0 without a clock edge; all reads return 0 after release.
REQ-040 NREGS=8: write 0xDEADBEEF to a0=0x1C, then read a0=0x3C -> 0xDEADBEEF (upper address bits ignored).
